// File: rtl/pattern_seq_engine.sv
// Multi-lane test-pattern generator: inc, dec, LFSR and walking-ones beats
// on a valid/ready stream, restartable on any rising edge of i_start.
module pattern_seq_engine #(
  parameter int OUTPUT_WIDTH    = 256,
  parameter int WORD_WIDTH      = 32,
  parameter int BURST_CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_start,
  input  logic [1:0]                 i_mode,
  input  logic [WORD_WIDTH-1:0]      i_seed,
  input  logic [BURST_CNT_WIDTH-1:0] i_burst_len,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUTPUT_WIDTH-1:0]    o_dout,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [BURST_CNT_WIDTH-1:0] o_count
);

  localparam int NUM_WORDS =
    (OUTPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam logic [WORD_WIDTH-1:0] W_LANE = WORD_WIDTH'(WORD_WIDTH);
  localparam logic [WORD_WIDTH-1:0] ONE_W  = WORD_WIDTH'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] ONE_C = BURST_CNT_WIDTH'(1);

  if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8 ||
      WORD_WIDTH > OUTPUT_WIDTH) begin : g_bad_param
    $error("WORD_WIDTH must be a multiple of 8 and <= OUTPUT_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic                         start_dly_q, start_dly_d;
  logic [1:0]                   mode_q, mode_d;
  logic [WORD_WIDTH-1:0]        base_q, base_d;
  logic [BURST_CNT_WIDTH-1:0]   len_q, len_d;
  logic [BURST_CNT_WIDTH-1:0]   count_q, count_d;
  logic                         valid_q, valid_d;
  logic [OUTPUT_WIDTH-1:0]      dout_q, dout_d;

  logic                         start_edge;
  logic                         accept;
  logic [WORD_WIDTH-1:0]        next_base;

  function automatic logic [WORD_WIDTH-1:0] rotl(
    input logic [WORD_WIDTH-1:0] s,
    input int                    r
  );
    if (r == 0) return s;
    return (s << r) | (s >> (WORD_WIDTH - r));
  endfunction

  // Base is the LFSR state in mode 2 and the bit position in mode 3.
  function automatic logic [WORD_WIDTH-1:0] load_base(
    input logic [1:0]            mode,
    input logic [WORD_WIDTH-1:0] seed
  );
    unique case (mode)
      2'd2:    return (seed == '0) ? ONE_W : seed;
      2'd3:    return seed % W_LANE;
      default: return seed;
    endcase
  endfunction

  function automatic logic [WORD_WIDTH-1:0] advance(
    input logic [1:0]            mode,
    input logic [WORD_WIDTH-1:0] b
  );
    unique case (mode)
      2'd0:    return b + ONE_W;
      2'd1:    return b - ONE_W;
      2'd2:    return {b[WORD_WIDTH-2:0],
                       b[WORD_WIDTH-1] ^ b[WORD_WIDTH-3] ^
                       b[WORD_WIDTH-4] ^ b[WORD_WIDTH-5]};
      default: return (b == W_LANE - ONE_W) ? '0 : b + ONE_W;
    endcase
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] make_beat(
    input logic [1:0]            mode,
    input logic [WORD_WIDTH-1:0] b
  );
    logic [OUTPUT_WIDTH-1:0] beat;
    logic [WORD_WIDTH-1:0]   idx;
    logic [WORD_WIDTH-1:0]   lane;
    beat = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      idx = WORD_WIDTH'(i);
      unique case (mode)
        2'd0:    lane = b + idx;
        2'd1:    lane = b - idx;
        2'd2:    lane = rotl(b, i % WORD_WIDTH) ^ idx;
        default: lane = ONE_W << b;
      endcase
      // The top lane may be only partly visible on o_dout.
      for (int k = 0; k < WORD_WIDTH; k++) begin
        if (i * WORD_WIDTH + k < OUTPUT_WIDTH) begin
          beat[i * WORD_WIDTH + k] = lane[k];
        end
      end
    end
    return beat;
  endfunction

  assign start_edge = i_start & ~start_dly_q;
  assign accept     = valid_q & i_ready;
  assign next_base  = advance(mode_q, base_q);

  always_comb begin
    state_d     = state_q;
    start_dly_d = i_start;
    mode_d      = mode_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    valid_d     = valid_q;
    dout_d      = dout_q;
    if (start_edge) begin
      mode_d  = i_mode;
      len_d   = i_burst_len;
      base_d  = load_base(i_mode, i_seed);
      count_d = '0;
      valid_d = 1'b1;
      state_d = ST_RUN;
      dout_d  = make_beat(i_mode, base_d);
    end else if (accept) begin
      base_d  = next_base;
      count_d = count_q + ONE_C;
      dout_d  = make_beat(mode_q, next_base);
      if (len_q != '0 && count_d == len_q) begin
        state_d = ST_DONE;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      start_dly_q <= 1'b0;
      mode_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
    end
  end

  assign o_valid = valid_q;
  assign o_dout  = dout_q;
  assign o_busy  = (state_q == ST_RUN);
  assign o_done  = (state_q == ST_DONE);
  assign o_count = count_q;

endmodule
